// File: rtl/data_checker_unit.sv
// Multi-channel data checker: compares observed words against an expected
// stream and reports pass/fail pulses, saturating counters and a sticky error.
module data_checker_unit #(
    parameter int G_NB_CHECKER         = 2,
    parameter int G_CHECKER_DATA_WIDTH = 32,
    parameter int G_CNT_WIDTH          = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [G_NB_CHECKER-1:0]                    i_start,
    input  logic [G_NB_CHECKER-1:0]                    i_use_valid,
    input  logic [G_NB_CHECKER-1:0]                    i_clear,
    input  logic [G_NB_CHECKER*G_CHECKER_DATA_WIDTH-1:0] i_data,
    input  logic [G_NB_CHECKER-1:0]                    i_data_valid,
    input  logic [G_NB_CHECKER*G_CHECKER_DATA_WIDTH-1:0] i_exp_data,
    input  logic [G_NB_CHECKER-1:0]                    i_exp_valid,
    output logic [G_NB_CHECKER-1:0]                    o_exp_ready,
    output logic [G_NB_CHECKER-1:0]                    o_check_done,
    output logic [G_NB_CHECKER-1:0]                    o_check_ok,
    output logic [G_NB_CHECKER-1:0]                    o_check_err,
    output logic [G_NB_CHECKER*G_CNT_WIDTH-1:0]        o_chk_cnt,
    output logic [G_NB_CHECKER*G_CNT_WIDTH-1:0]        o_err_cnt,
    output logic [G_NB_CHECKER-1:0]                    o_sticky_err
);

    localparam int N = G_NB_CHECKER;
    localparam int W = G_CHECKER_DATA_WIDTH;
    localparam int C = G_CNT_WIDTH;

    for (genvar k = 0; k < N; k++) begin : g_ch
        logic         ev;
        logic         match;
        logic         done_q;
        logic         ok_q;
        logic         err_q;
        logic         sticky_q;
        logic [C-1:0] chk_q;
        logic [C-1:0] err_cnt_q;

        assign ev    = i_start[k] & i_exp_valid[k] &
                       (~i_use_valid[k] | i_data_valid[k]);
        assign match = i_data[k*W +: W] == i_exp_data[k*W +: W];

        // Pop is suppressed in reset so the source never loses a word.
        assign o_exp_ready[k] = ev & ~rst;

        always_ff @(posedge clk) begin
            if (rst) begin
                done_q    <= 1'b0;
                ok_q      <= 1'b0;
                err_q     <= 1'b0;
                sticky_q  <= 1'b0;
                chk_q     <= '0;
                err_cnt_q <= '0;
            end else begin
                done_q <= ev;
                ok_q   <= ev & match;
                err_q  <= ev & ~match;
                // Clear wins over a same-cycle event; pulses still fire.
                if (i_clear[k]) begin
                    sticky_q  <= 1'b0;
                    chk_q     <= '0;
                    err_cnt_q <= '0;
                end else if (ev) begin
                    if (chk_q != '1) begin
                        chk_q <= chk_q + C'(1);
                    end
                    if (!match) begin
                        sticky_q <= 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_q <= err_cnt_q + C'(1);
                        end
                    end
                end
            end
        end

        assign o_check_done[k]      = done_q;
        assign o_check_ok[k]        = ok_q;
        assign o_check_err[k]       = err_q;
        assign o_sticky_err[k]      = sticky_q;
        assign o_chk_cnt[k*C +: C]  = chk_q;
        assign o_err_cnt[k*C +: C]  = err_cnt_q;
    end

endmodule

// File: tb/tb_data_checker_unit.sv
// Directed bench for data_checker_unit with 2 channels, 32-bit data and
// 4-bit counters so saturation is reachable in a few cycles.
module tb_data_checker_unit;

    localparam int N = 2;
    localparam int W = 32;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   start, use_valid, clear, data_valid, exp_valid;
    logic [N*W-1:0] data, exp_data;
    logic [N-1:0]   exp_ready, done, ok, err, sticky;
    logic [N*C-1:0] chk_cnt, err_cnt;

    int tests = 0;
    int fails = 0;
    int pops  = 0;

    always #5 clk = ~clk;

    data_checker_unit #(
        .G_NB_CHECKER(N),
        .G_CHECKER_DATA_WIDTH(W),
        .G_CNT_WIDTH(C)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_start(start),
        .i_use_valid(use_valid),
        .i_clear(clear),
        .i_data(data),
        .i_data_valid(data_valid),
        .i_exp_data(exp_data),
        .i_exp_valid(exp_valid),
        .o_exp_ready(exp_ready),
        .o_check_done(done),
        .o_check_ok(ok),
        .o_check_err(err),
        .o_chk_cnt(chk_cnt),
        .o_err_cnt(err_cnt),
        .o_sticky_err(sticky)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        start      = '0;
        use_valid  = '0;
        clear      = '0;
        data_valid = '0;
        exp_valid  = '0;
        data       = '0;
        exp_data   = '0;
        step();
        step();
        chk("rst_done", done, 0);
        chk("rst_ok", ok, 0);
        chk("rst_err", err, 0);
        chk("rst_chk_cnt", chk_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_sticky", sticky, 0);

        // 1: ch0 single matching compare, use_valid off
        rst          = 1'b0;
        start        = 2'b01;
        exp_valid    = 2'b01;
        data[31:0]   = 32'hA5A5_0001;
        exp_data[31:0] = 32'hA5A5_0001;
        #1;
        chk("t1_ready", exp_ready, 2'b01);
        step();
        start = 2'b00;
        chk("t1_done", done, 2'b01);
        chk("t1_ok", ok, 2'b01);
        chk("t1_err", err, 2'b00);
        chk("t1_chk_cnt0", chk_cnt[3:0], 1);
        chk("t1_err_cnt0", err_cnt[3:0], 0);

        // 2: ch1 waits for data_valid, then one mismatch
        exp_valid       = 2'b10;
        start           = 2'b10;
        use_valid       = 2'b10;
        data[63:32]     = 32'h10;
        exp_data[63:32] = 32'h11;
        for (int i = 0; i < 4; i++) begin
            data_valid = (i == 3) ? 2'b10 : 2'b00;
            #1;
            if (exp_ready[1]) pops++;
            step();
        end
        data_valid = 2'b00;
        chk("t2_pops", pops, 1);
        chk("t2_done", done, 2'b10);
        chk("t2_err", err, 2'b10);
        chk("t2_ok", ok, 2'b00);
        chk("t2_chk_cnt1", chk_cnt[7:4], 1);
        chk("t2_err_cnt1", err_cnt[7:4], 1);
        chk("t2_sticky", sticky, 2'b10);
        step();
        chk("t2_done_after", done, 2'b00);
        start     = 2'b00;
        use_valid = 2'b00;

        // 3: starved expected stream
        start     = 2'b01;
        exp_valid = 2'b00;
        #1;
        chk("t3_ready", exp_ready, 2'b00);
        step();
        chk("t3_done", done, 2'b00);
        chk("t3_chk_cnt0", chk_cnt[3:0], 1);

        // 4: 20 mismatches on ch0 saturate both counters
        exp_valid      = 2'b01;
        data[31:0]     = 32'h0;
        exp_data[31:0] = 32'h1;
        for (int i = 0; i < 20; i++) step();
        chk("t4_chk_sat", chk_cnt[3:0], 15);
        chk("t4_err_sat", err_cnt[3:0], 15);
        chk("t4_sticky", sticky, 2'b11);
        clear = 2'b01;
        step();
        clear = 2'b00;
        start = 2'b00;
        chk("t4_clr_err_pulse", err, 2'b01);
        chk("t4_clr_chk", chk_cnt[3:0], 0);
        chk("t4_clr_err", err_cnt[3:0], 0);
        chk("t4_clr_sticky", sticky, 2'b10);
        chk("t4_ch1_hold", chk_cnt[7:4], 1);

        // 6: simultaneous events, ch0 match, ch1 mismatch
        start     = 2'b11;
        exp_valid = 2'b11;
        data      = {32'h0000_0020, 32'h1234_5678};
        exp_data  = {32'h0000_0021, 32'h1234_5678};
        #1;
        chk("t6_ready", exp_ready, 2'b11);
        step();
        chk("t6_ok", ok, 2'b01);
        chk("t6_err", err, 2'b10);
        chk("t6_chk_cnt", chk_cnt, {4'd2, 4'd1});
        chk("t6_err_cnt", err_cnt, {4'd2, 4'd0});

        // 5: reset with events still pending
        rst = 1'b1;
        #1;
        chk("t5_ready_in_rst", exp_ready, 2'b00);
        step();
        chk("t5_done", done, 0);
        chk("t5_ok", ok, 0);
        chk("t5_err", err, 0);
        chk("t5_chk_cnt", chk_cnt, 0);
        chk("t5_err_cnt", err_cnt, 0);
        chk("t5_sticky", sticky, 0);
        rst   = 1'b0;
        start = 2'b00;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
